// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, forwarding constants and select-width helper for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN, MISS, DRAIN} state_t;
  localparam int FWD_RF = 0;
  function automatic int selw(input int nstage);
    return $clog2(nstage + 1);
  endfunction
endpackage

// File: rtl/fwd_select.sv
// fwd_select: priority-encodes the nearest downstream stage that produces one ID source operand
module fwd_select
  import hazard_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int REGW   = 5,
  parameter int SELW   = selw(NSTAGE)
) (
  input  logic [REGW-1:0]        src,
  input  logic                   vld,
  input  logic [NSTAGE*REGW-1:0] stg_rd,
  input  logic [NSTAGE-1:0]      stg_rfwr,
  input  logic [NSTAGE-1:0]      stg_late,
  output logic [SELW-1:0]        sel,
  output logic                   late
);
  // Scan farthest-first so the nearest matching stage is the one that sticks
  always_comb begin
    sel  = SELW'(FWD_RF);
    late = 1'b0;
    for (int k = NSTAGE; k >= 1; k--)
      if (vld && stg_rfwr[k-1] && src != '0 && stg_rd[(k-1)*REGW +: REGW] == src) begin
        sel  = SELW'(k);
        late = stg_late[k-1];
      end
  end
endmodule

// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: forwarding selects, stall FSM, pipeline enables and stall counter for the in-order pipeline
module hazard_ctrl_param
  import hazard_pkg::*;
#(
  parameter int NSTAGE = 4,
  parameter int NSRC   = 2,
  parameter int REGW   = 5,
  parameter int CNTW   = 16,
  parameter int SELW   = selw(NSTAGE)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NSRC*REGW-1:0]   id_src,
  input  logic [NSRC-1:0]        id_src_vld,
  input  logic [NSTAGE*REGW-1:0] stg_rd,
  input  logic [NSTAGE-1:0]      stg_rfwr,
  input  logic [NSTAGE-1:0]      stg_late,
  input  logic                   flush,
  input  logic                   icache_data_ok,
  input  logic                   dcache_req,
  input  logic                   dcache_addr_ok,
  input  logic                   dcache_wait,
  input  logic                   dcache_data_ok,
  input  logic                   md_busy,
  input  logic                   md_visit,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   pc_we,
  output logic                   if_we,
  output logic                   id_we,
  output logic [NSTAGE:0]        stg_we,
  output logic                   id_bubble,
  output logic                   stall,
  output logic [CNTW-1:0]        stall_cnt
);
  state_t               state;
  logic [NSRC*SELW-1:0] sel_raw;
  logic [NSRC-1:0]      late_v;
  logic                 mem_miss, pend, hz, hold, lo, tl, fe;
  genvar i;
  generate
    for (i = 0; i < NSRC; i++) begin : g_fwd
      fwd_select #(.NSTAGE(NSTAGE), .REGW(REGW), .SELW(SELW)) u_fs (
        .src(id_src[i*REGW +: REGW]), .vld(id_src_vld[i]), .stg_rd(stg_rd),
        .stg_rfwr(stg_rfwr), .stg_late(stg_late),
        .sel(sel_raw[i*SELW +: SELW]), .late(late_v[i])
      );
    end
  endgenerate
  assign fwd_sel = resetn ? sel_raw : '0;
  // A flush from RUN overrides both the miss hold and the data/md stalls
  always_comb begin
    pend     = dcache_wait & ~dcache_data_ok;
    mem_miss = pend | (dcache_req & ~dcache_addr_ok) | ~icache_data_ok;
    hz       = ((md_busy & md_visit) | (|late_v)) & ~flush;
    hold     = state == MISS || (state == RUN && mem_miss && !flush);
    fe       = ~resetn | (~hold & ~hz);
    lo       = ~resetn | ~hold;
    tl       = ~resetn | (state == RUN && flush ? ~pend : state == DRAIN ? 1'b0 : ~hold);
  end
  assign pc_we     = fe;
  assign if_we     = fe;
  assign id_we     = fe;
  assign id_bubble = resetn & ~hold & hz;
  assign stg_we    = {{2{tl}}, {(NSTAGE-1){lo}}};
  assign stall     = ~(pc_we & if_we);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNTW'(1);
      case (state)
        RUN:     state <= flush && pend ? DRAIN : mem_miss ? MISS : RUN;
        MISS:    state <= flush ? (pend ? DRAIN : RUN) : mem_miss ? MISS : RUN;
        DRAIN:   state <= dcache_data_ok ? RUN : DRAIN;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb_hazard_ctrl_param: directed checks of forwarding, stalls, stall FSM and counter saturation
module tb_hazard_ctrl_param;
  import hazard_pkg::*;
  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  id_src;
  logic [1:0]  id_src_vld;
  logic [19:0] stg_rd;
  logic [3:0]  stg_rfwr, stg_late;
  logic        flush, icache_data_ok, dcache_req, dcache_addr_ok, dcache_wait, dcache_data_ok;
  logic        md_busy, md_visit;
  logic [5:0]  fwd_sel, fwd_sel_s;
  logic        pc_we, if_we, id_we, id_bubble, stall;
  logic        pc_we_s, if_we_s, id_we_s, id_bubble_s, stall_s;
  logic [4:0]  stg_we, stg_we_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  hazard_ctrl_param u_dut (
    .clk(clk), .resetn(resetn), .id_src(id_src), .id_src_vld(id_src_vld), .stg_rd(stg_rd),
    .stg_rfwr(stg_rfwr), .stg_late(stg_late), .flush(flush), .icache_data_ok(icache_data_ok),
    .dcache_req(dcache_req), .dcache_addr_ok(dcache_addr_ok), .dcache_wait(dcache_wait),
    .dcache_data_ok(dcache_data_ok), .md_busy(md_busy), .md_visit(md_visit), .fwd_sel(fwd_sel),
    .pc_we(pc_we), .if_we(if_we), .id_we(id_we), .stg_we(stg_we), .id_bubble(id_bubble),
    .stall(stall), .stall_cnt(stall_cnt)
  );
  hazard_ctrl_param #(.CNTW(4)) u_small (
    .clk(clk), .resetn(resetn), .id_src(id_src), .id_src_vld(id_src_vld), .stg_rd(stg_rd),
    .stg_rfwr(stg_rfwr), .stg_late(stg_late), .flush(flush), .icache_data_ok(icache_data_ok),
    .dcache_req(dcache_req), .dcache_addr_ok(dcache_addr_ok), .dcache_wait(dcache_wait),
    .dcache_data_ok(dcache_data_ok), .md_busy(md_busy), .md_visit(md_visit), .fwd_sel(fwd_sel_s),
    .pc_we(pc_we_s), .if_we(if_we_s), .id_we(id_we_s), .stg_we(stg_we_s), .id_bubble(id_bubble_s),
    .stall(stall_s), .stall_cnt(stall_cnt_s)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    resetn = 1'b0; id_src = '0; id_src_vld = 2'b11; stg_rd = '0; stg_rfwr = '0; stg_late = '0;
    flush = 0; icache_data_ok = 0; dcache_req = 0; dcache_addr_ok = 1; dcache_wait = 0;
    dcache_data_ok = 0; md_busy = 0; md_visit = 0;
    id_src[4:0] = 5'd3; stg_rd[4:0] = 5'd3; stg_rfwr = 4'b0001;
    tick();
    tick();
    chk("rst_pc_we", 32'(pc_we), 1);
    chk("rst_stg_we", 32'(stg_we), 5'h1f);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_bubble", 32'(id_bubble), 0);
    chk("rst_fwd_sel", 32'(fwd_sel), 0);
    chk("rst_state", 32'(u_dut.state), 32'(RUN));
    chk("rst_cnt", 32'(stall_cnt), 0);
    icache_data_ok = 1;
    resetn = 1'b1;
    // forwarding: nearest writer of $3 wins
    stg_rd = {5'd0, 5'd3, 5'd0, 5'd3}; stg_rfwr = 4'b0101;
    #1 chk("fwd_near", 32'(fwd_sel[2:0]), 1);
    stg_rfwr = 4'b0100;
    #1 chk("fwd_far", 32'(fwd_sel[2:0]), 3);
    chk("fwd_nostall", 32'(stall), 0);
    id_src_vld = 2'b10;
    #1 chk("fwd_invalid", 32'(fwd_sel[2:0]), 0);
    id_src_vld = 2'b11;
    id_src[4:0] = 5'd0; stg_rd = '0; stg_rfwr = 4'b0001;
    #1 chk("fwd_r0", 32'(fwd_sel[2:0]), 0);
    // load-use on source 1
    id_src[9:5] = 5'd5; stg_rd[4:0] = 5'd5; stg_late = 4'b0001;
    #1 chk("lu_stall", 32'(stall), 1);
    chk("lu_bubble", 32'(id_bubble), 1);
    chk("lu_stg_we", 32'(stg_we), 5'h1f);
    chk("lu_pc_we", 32'(pc_we), 0);
    chk("lu_id_we", 32'(id_we), 0);
    stg_late = '0;
    #1 chk("lu_fwd", 32'(fwd_sel[5:3]), 1);
    chk("lu_clear", 32'(stall), 0);
    md_busy = 1; md_visit = 1;
    #1 chk("md_stall", 32'(stall), 1);
    md_busy = 0; md_visit = 0; stg_rfwr = '0;
    // D-cache miss
    resetn = 0; tick(); resetn = 1;
    chk("dm_cnt0", 32'(stall_cnt), 0);
    dcache_wait = 1;
    #1 chk("dm_stg_we", 32'(stg_we), 0);
    chk("dm_pc_we", 32'(pc_we), 0);
    tick(); tick(); tick();
    chk("dm_state", 32'(u_dut.state), 32'(MISS));
    chk("dm_cnt3", 32'(stall_cnt), 3);
    dcache_data_ok = 1;
    tick();
    chk("dm_run", 32'(u_dut.state), 32'(RUN));
    chk("dm_cnt4", 32'(stall_cnt), 4);
    // flush from RUN with outstanding data and md_stall present
    dcache_data_ok = 0; flush = 1; md_busy = 1; md_visit = 1;
    #1 chk("fl_stall", 32'(stall), 0);
    chk("fl_bubble", 32'(id_bubble), 0);
    chk("fl_stg_we", 32'(stg_we), 5'b00111);
    tick();
    chk("fl_drain", 32'(u_dut.state), 32'(DRAIN));
    flush = 0; md_busy = 0; md_visit = 0;
    #1 chk("dr_pc_we", 32'(pc_we), 1);
    chk("dr_stg_we", 32'(stg_we), 5'b00111);
    tick();
    chk("dr_hold", 32'(u_dut.state), 32'(DRAIN));
    chk("dr_cnt", 32'(stall_cnt), 4);
    dcache_data_ok = 1;
    tick();
    chk("dr_run", 32'(u_dut.state), 32'(RUN));
    // flush arriving while already in MISS
    dcache_data_ok = 0;
    tick();
    chk("mf_miss", 32'(u_dut.state), 32'(MISS));
    flush = 1;
    #1 chk("mf_stg_we", 32'(stg_we), 0);
    tick();
    flush = 0;
    chk("mf_drain", 32'(u_dut.state), 32'(DRAIN));
    dcache_data_ok = 1;
    tick();
    dcache_data_ok = 0; dcache_wait = 0;
    chk("mf_run", 32'(u_dut.state), 32'(RUN));
    // saturation on the narrow counter
    resetn = 0; tick(); resetn = 1;
    dcache_wait = 1;
    for (int n = 0; n < 20; n++) tick();
    chk("sat_small", 32'(stall_cnt_s), 15);
    chk("sat_main", 32'(stall_cnt), 20);
    tick();
    chk("sat_hold", 32'(stall_cnt_s), 15);
    resetn = 0;
    #1 chk("rm_stall", 32'(stall_s), 0);
    chk("rm_stg_we", 32'(stg_we_s), 5'h1f);
    tick();
    chk("rm_state", 32'(u_small.state), 32'(RUN));
    chk("rm_cnt", 32'(stall_cnt_s), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
